// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives PMEM, pairs returned words with their PC.
// Optional FETCH_JUMP_COUNT_EN adds a saturating 16-bit taken-jump counter on out_jump_count.
module fetch_stage #(
  parameter int PC_WIDTH        = 12,
  parameter int PMEM_ADDR_WIDTH = 12,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int FLUSH_CYCLES    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_jump,
  input  logic [PC_WIDTH-1:0]        in_jump_target,
  input  logic                       in_stall,
  input  logic [PMEM_WORD_WIDTH-1:0] in_pmem_data,
  output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_flush
`ifdef FETCH_JUMP_COUNT_EN
  ,
  output logic [15:0]                out_jump_count
`endif
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_d1_q, pc_d1_d;
  logic                valid_q, valid_d;
  logic [2:0]          flush_cnt_q, flush_cnt_d;

  always_comb begin
    pc_d        = pc_q;
    pc_d1_d     = pc_d1_q;
    valid_d     = valid_q;
    flush_cnt_d = flush_cnt_q;

    // A jump overrides a stall; the word in flight from the old PC is squashed.
    if (in_jump) begin
      pc_d    = in_jump_target;
      pc_d1_d = pc_q;
      valid_d = 1'b0;
    end else if (!in_stall) begin
      pc_d    = pc_q + 1'b1;
      pc_d1_d = pc_q;
      valid_d = 1'b1;
    end

    // The flush window keeps counting down even while stalled.
    if (in_jump) begin
      flush_cnt_d = FLUSH_LOAD;
    end else if (flush_cnt_q != 3'd0) begin
      flush_cnt_d = flush_cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q        <= '0;
      pc_d1_q     <= '0;
      valid_q     <= 1'b0;
      flush_cnt_q <= 3'd0;
    end else begin
      pc_q        <= pc_d;
      pc_d1_q     <= pc_d1_d;
      valid_q     <= valid_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign out_pmem_addr = PMEM_ADDR_WIDTH'(pc_q);
  assign out_instr     = valid_q ? in_pmem_data : '0;
  assign out_pc        = pc_d1_q;
  assign out_flush     = (flush_cnt_q != 3'd0);

`ifdef FETCH_JUMP_COUNT_EN
  logic [15:0] jump_count_q, jump_count_d;

  always_comb begin
    jump_count_d = jump_count_q;
    if (in_jump && (jump_count_q != 16'hFFFF)) begin
      jump_count_d = jump_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jump_count_q <= 16'd0;
    end else begin
      jump_count_q <= jump_count_d;
    end
  end

  assign out_jump_count = jump_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; PMEM model returns 0x1000+addr one cycle later.
// Build with FETCH_JUMP_COUNT_EN defined to also exercise out_jump_count.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic        in_jump;
  logic [11:0] in_jump_target;
  logic        in_stall;
  logic [15:0] in_pmem_data;
  logic [11:0] out_pmem_addr;
  logic [15:0] out_instr;
  logic [11:0] out_pc;
  logic        out_flush;
`ifdef FETCH_JUMP_COUNT_EN
  logic [15:0] out_jump_count;
`endif

  int checks;
  int failures;

  fetch_stage #(
    .PC_WIDTH(12), .PMEM_ADDR_WIDTH(12), .PMEM_WORD_WIDTH(16), .FLUSH_CYCLES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_jump(in_jump),
    .in_jump_target(in_jump_target),
    .in_stall(in_stall),
    .in_pmem_data(in_pmem_data),
    .out_pmem_addr(out_pmem_addr),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_flush(out_flush)
`ifdef FETCH_JUMP_COUNT_EN
    ,
    .out_jump_count(out_jump_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // PMEM model: synchronous read; output register held while fetch is stalled.
  always_ff @(posedge clock) begin
    if (!in_stall || in_jump) in_pmem_data <= 16'h1000 + 16'(out_pmem_addr);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_jump = 1'b0; in_jump_target = '0; in_stall = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (out_pmem_addr !== 12'h000) begin failures++; $display("FAIL rst_addr actual=%h required=%h", out_pmem_addr, 12'h000); end
    checks++; if (out_instr !== 16'h0000) begin failures++; $display("FAIL rst_instr actual=%h required=%h", out_instr, 16'h0000); end
    checks++; if (out_pc !== 12'h000) begin failures++; $display("FAIL rst_pc actual=%h required=%h", out_pc, 12'h000); end
    checks++; if (out_flush !== 1'b0) begin failures++; $display("FAIL rst_flush actual=%b required=%b", out_flush, 1'b0); end
`ifdef FETCH_JUMP_COUNT_EN
    checks++; if (out_jump_count !== 16'd0) begin failures++; $display("FAIL rst_jcount actual=%0d required=%0d", out_jump_count, 0); end
`endif
    reset = 1'b0;
    checks++; if (out_instr !== 16'h0000) begin failures++; $display("FAIL cyc1_instr actual=%h required=%h", out_instr, 16'h0000); end
    tick();
    checks++; if (out_instr !== 16'h1000 || out_pc !== 12'h000) begin failures++; $display("FAIL cyc2 actual=%h/%h required=1000/000", out_instr, out_pc); end
    tick();
    checks++; if (out_instr !== 16'h1001 || out_pc !== 12'h001) begin failures++; $display("FAIL cyc3 actual=%h/%h required=1001/001", out_instr, out_pc); end
    $display("test_reset done");
  endtask

  task automatic test_stall();
    repeat (5) tick();
    checks++; if (out_pmem_addr !== 12'h007 || out_instr !== 16'h1006 || out_pc !== 12'h006) begin failures++; $display("FAIL pre_stall actual=%h/%h/%h required=007/1006/006", out_pmem_addr, out_instr, out_pc); end
    in_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_pmem_addr !== 12'h007 || out_instr !== 16'h1006 || out_pc !== 12'h006) begin failures++; $display("FAIL stall_hold%0d actual=%h/%h/%h required=007/1006/006", i, out_pmem_addr, out_instr, out_pc); end
    end
    in_stall = 1'b0;
    tick();
    checks++; if (out_pmem_addr !== 12'h008 || out_instr !== 16'h1007 || out_pc !== 12'h007) begin failures++; $display("FAIL stall_release actual=%h/%h/%h required=008/1007/007", out_pmem_addr, out_instr, out_pc); end
    $display("test_stall done");
  endtask

  task automatic test_jump();
    apply_reset();
    repeat (5) tick();
    checks++; if (out_pmem_addr !== 12'h005) begin failures++; $display("FAIL jmp_start actual=%h required=%h", out_pmem_addr, 12'h005); end
    in_jump = 1'b1; in_jump_target = 12'h020;
    tick();
    in_jump = 1'b0;
    checks++; if (out_pmem_addr !== 12'h020 || out_instr !== 16'h0000 || out_flush !== 1'b1) begin failures++; $display("FAIL jmp_c1 actual=%h/%h/%b required=020/0000/1", out_pmem_addr, out_instr, out_flush); end
    tick();
    checks++; if (out_instr !== 16'h1020 || out_pc !== 12'h020 || out_flush !== 1'b1) begin failures++; $display("FAIL jmp_c2 actual=%h/%h/%b required=1020/020/1", out_instr, out_pc, out_flush); end
    tick();
    checks++; if (out_instr !== 16'h1021 || out_pc !== 12'h021 || out_flush !== 1'b0) begin failures++; $display("FAIL jmp_c3 actual=%h/%h/%b required=1021/021/0", out_instr, out_pc, out_flush); end
    $display("test_jump done");
  endtask

  task automatic test_back_to_back();
    in_jump = 1'b1; in_jump_target = 12'h010;
    tick();
    checks++; if (out_flush !== 1'b1 || out_pmem_addr !== 12'h010) begin failures++; $display("FAIL b2b_c1 actual=%b/%h required=1/010", out_flush, out_pmem_addr); end
    in_jump_target = 12'h030;
    tick();
    in_jump = 1'b0;
    checks++; if (out_flush !== 1'b1 || out_instr !== 16'h0000 || out_pmem_addr !== 12'h030) begin failures++; $display("FAIL b2b_c2 actual=%b/%h/%h required=1/0000/030", out_flush, out_instr, out_pmem_addr); end
    tick();
    checks++; if (out_flush !== 1'b1 || out_instr !== 16'h1030 || out_pc !== 12'h030) begin failures++; $display("FAIL b2b_c3 actual=%b/%h/%h required=1/1030/030", out_flush, out_instr, out_pc); end
    tick();
    checks++; if (out_flush !== 1'b0 || out_pc !== 12'h031) begin failures++; $display("FAIL b2b_c4 actual=%b/%h required=0/031", out_flush, out_pc); end
    $display("test_back_to_back done");
  endtask

  task automatic test_stall_jump();
    in_stall = 1'b1; in_jump = 1'b1; in_jump_target = 12'h040;
    tick();
    in_stall = 1'b0; in_jump = 1'b0;
    checks++; if (out_pmem_addr !== 12'h040 || out_instr !== 16'h0000 || out_flush !== 1'b1) begin failures++; $display("FAIL sj_c1 actual=%h/%h/%b required=040/0000/1", out_pmem_addr, out_instr, out_flush); end
    tick();
    checks++; if (out_instr !== 16'h1040 || out_pc !== 12'h040) begin failures++; $display("FAIL sj_c2 actual=%h/%h required=1040/040", out_instr, out_pc); end
    $display("test_stall_jump done");
  endtask

  task automatic test_wrap();
    in_jump = 1'b1; in_jump_target = 12'hFFE;
    tick();
    in_jump = 1'b0;
    checks++; if (out_pmem_addr !== 12'hFFE) begin failures++; $display("FAIL wrap_c0 actual=%h required=ffe", out_pmem_addr); end
    tick();
    checks++; if (out_pmem_addr !== 12'hFFF || out_pc !== 12'hFFE || out_instr !== 16'h1FFE) begin failures++; $display("FAIL wrap_c1 actual=%h/%h/%h required=fff/ffe/1ffe", out_pmem_addr, out_pc, out_instr); end
    tick();
    checks++; if (out_pmem_addr !== 12'h000 || out_pc !== 12'hFFF || out_instr !== 16'h1FFF) begin failures++; $display("FAIL wrap_c2 actual=%h/%h/%h required=000/fff/1fff", out_pmem_addr, out_pc, out_instr); end
    tick();
    checks++; if (out_pmem_addr !== 12'h001 || out_pc !== 12'h000 || out_instr !== 16'h1000) begin failures++; $display("FAIL wrap_c3 actual=%h/%h/%h required=001/000/1000", out_pmem_addr, out_pc, out_instr); end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid_flush();
    in_jump = 1'b1; in_jump_target = 12'h122;
    tick();
    in_jump = 1'b0;
    tick();
    checks++; if (out_pmem_addr !== 12'h123 || out_flush !== 1'b1) begin failures++; $display("FAIL mid_pre actual=%h/%b required=123/1", out_pmem_addr, out_flush); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_pmem_addr !== 12'h000 || out_instr !== 16'h0000 || out_pc !== 12'h000 || out_flush !== 1'b0) begin failures++; $display("FAIL mid_async actual=%h/%h/%h/%b required=000/0000/000/0", out_pmem_addr, out_instr, out_pc, out_flush); end
`ifdef FETCH_JUMP_COUNT_EN
    checks++; if (out_jump_count !== 16'd0) begin failures++; $display("FAIL mid_jcount actual=%0d required=0", out_jump_count); end
`endif
    tick();
    reset = 1'b0;
    checks++; if (out_pmem_addr !== 12'h000 || out_flush !== 1'b0) begin failures++; $display("FAIL mid_rel actual=%h/%b required=000/0", out_pmem_addr, out_flush); end
    tick();
    checks++; if (out_instr !== 16'h1000 || out_pc !== 12'h000 || out_flush !== 1'b0) begin failures++; $display("FAIL mid_resume actual=%h/%h/%b required=1000/000/0", out_instr, out_pc, out_flush); end
`ifdef FETCH_JUMP_COUNT_EN
    in_jump = 1'b1; in_jump_target = 12'h050;
    tick();
    in_jump_target = 12'h060;
    tick();
    in_jump = 1'b0;
    tick();
    checks++; if (out_jump_count !== 16'd2) begin failures++; $display("FAIL jcount2 actual=%0d required=2", out_jump_count); end
`endif
    $display("test_reset_mid_flush done");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    in_jump = 1'b0;
    in_jump_target = '0;
    in_stall = 1'b0;
    test_reset();
    test_stall();
    test_jump();
    test_back_to_back();
    test_stall_jump();
    test_wrap();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
